// File: rtl/pipe_ctrl_seq_pkg.sv
// Shared constants, stall encodings and controller state type for pipe_ctrl_seq.
package pipe_ctrl_seq_pkg;

    localparam logic [5:0] STALL_NONE  = 6'b000000;
    localparam logic [5:0] STALL_IF_ID = 6'b000111;
    localparam logic [5:0] STALL_EX    = 6'b001111;
    localparam logic [5:0] STALL_MEM   = 6'b011111;
    localparam logic [5:0] STALL_ALL   = 6'b111111;

    localparam logic [31:0] ERET_CODE_DEF  = 32'h0000000E;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h00000020;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_FLUSH
    } ctrl_state_e;

    // Priority merge of stage requests while running; an exception freezes everything.
    function automatic logic [5:0] stall_encode(input logic exc, input logic mem,
                                                input logic ex, input logic id,
                                                input logic ifw);
        if (exc)            return STALL_ALL;
        else if (mem)       return STALL_MEM;
        else if (ex)        return STALL_EX;
        else if (id || ifw) return STALL_IF_ID;
        else                return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_seq_stall_watchdog.sv
// Counts consecutive stalled cycles, saturates at STALL_TIMEOUT and pulses once per episode.
module stall_watchdog #(
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic stalled,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_TIMEOUT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !stalled) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // cnt holds the stalled cycles before this one, so the pulse lands on the
    // STALL_TIMEOUT-th stalled cycle; saturation keeps it from repeating.
    assign timeout = stalled && (cnt == LIMIT - CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl_seq.sv
// Pipeline stall/flush sequencer with exception redirect and stall watchdog.
// Optional performance counters are built when CTRL_PERF_EN is defined.
module pipe_ctrl_seq
    import pipe_ctrl_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
    parameter logic [31:0] ERET_CODE     = ERET_CODE_DEF,
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        if_busy_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout_o,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    ctrl_state_e state;
    logic [31:0] target;
    logic        exc_any;
    logic [31:0] exc_target;

    assign exc_any    = |excepttype_i;
    assign exc_target = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;

    always_comb begin
        stall = STALL_NONE;
        if (!rst) begin
            unique case (state)
                ST_RUN:   stall = stall_encode(exc_any, stallreq_mem_i, stallreq_ex_i,
                                               stallreq_id_i, stallreq_if_i);
                ST_DRAIN: stall = STALL_ALL;
                ST_FLUSH: stall = STALL_NONE;
                default:  stall = STALL_NONE;
            endcase
        end
    end

    // flush/new_pc are loaded on the edge that enters FLUSH so they are valid
    // for exactly the FLUSH cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            flush  <= 1'b0;
            new_pc <= '0;
            target <= '0;
        end else begin
            flush <= 1'b0;
            unique case (state)
                ST_RUN: begin
                    if (exc_any) begin
                        target <= exc_target;
                        if (if_busy_i) begin
                            state <= ST_DRAIN;
                        end else begin
                            state  <= ST_FLUSH;
                            flush  <= 1'b1;
                            new_pc <= exc_target;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!if_busy_i) begin
                        state  <= ST_FLUSH;
                        flush  <= 1'b1;
                        new_pc <= target;
                    end
                end
                ST_FLUSH: state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .stalled((state == ST_RUN) && stall[0]),
        .timeout(stall_timeout_o)
    );

`ifdef CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + {31'b0, stall[0]};
            perf_flush_cnt <= perf_flush_cnt + {31'b0, flush};
        end
    end
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Scoreboard bench for pipe_ctrl_seq: directed scenarios then randomized traffic
// against a cycle-level behavioural model of the redirect/stall rules.
module tb_pipe_ctrl_seq;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic        if_busy_i;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout_o;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl_seq #(
        .EXC_VECTOR   (32'h00000020),
        .ERET_CODE    (32'h0000000E),
        .STALL_TIMEOUT(TMO),
        .CNT_W        (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if_i  (stallreq_if_i),
        .stallreq_id_i  (stallreq_id_i),
        .stallreq_ex_i  (stallreq_ex_i),
        .stallreq_mem_i (stallreq_mem_i),
        .if_busy_i      (if_busy_i),
        .excepttype_i   (excepttype_i),
        .cp0_epc_i      (cp0_epc_i),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .stall_timeout_o(stall_timeout_o),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    typedef struct {
        string       tag;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] npc;
        logic        to;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: mode 0 = running, 1 = redirect waiting on the bus, 2 = redirect cycle.
    int          mode  = 0;
    bit          m_fl  = 1'b0;
    logic [31:0] m_npc = '0;
    logic [31:0] m_tgt = '0;
    int          m_run = 0;
    logic [31:0] m_ps  = '0;
    logic [31:0] m_pf  = '0;

    task automatic chk(input string tag, input string what, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s.%s got=%h want=%h (t=%0t)", tag, what, got, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.tag, "stall",   {26'b0, stall},           {26'b0, e.stall});
                chk(e.tag, "flush",   {31'b0, flush},           {31'b0, e.flush});
                chk(e.tag, "new_pc",  new_pc,                   e.npc);
                chk(e.tag, "timeout", {31'b0, stall_timeout_o}, {31'b0, e.to});
                chk(e.tag, "perf_st", perf_stall_cnt,           e.ps);
                chk(e.tag, "perf_fl", perf_flush_cnt,           e.pf);
            end
        end
    end

    task automatic step(input bit r, input bit ifw, input bit id, input bit ex, input bit mem,
                        input bit busy, input logic [31:0] exc, input logic [31:0] epc,
                        input bit push, input string tag);
        exp_t e;
        bit   run_stall;
        @(posedge clk);
        #1;
        rst = r; stallreq_if_i = ifw; stallreq_id_i = id; stallreq_ex_i = ex;
        stallreq_mem_i = mem; if_busy_i = busy; excepttype_i = exc; cp0_epc_i = epc;

        if (r)                 e.stall = 6'd0;
        else if (mode == 1)    e.stall = 6'b111111;
        else if (mode == 2)    e.stall = 6'd0;
        else if (exc != 0)     e.stall = 6'b111111;
        else if (mem)          e.stall = 6'b011111;
        else if (ex)           e.stall = 6'b001111;
        else if (id || ifw)    e.stall = 6'b000111;
        else                   e.stall = 6'd0;
        run_stall = !r && mode == 0 && e.stall[0];
        e.tag   = tag;
        e.flush = m_fl;
        e.npc   = m_npc;
        e.to    = run_stall && (m_run + 1 == int'(TMO));
`ifdef CTRL_PERF_EN
        e.ps = m_ps;
        e.pf = m_pf;
`else
        e.ps = '0;
        e.pf = '0;
`endif
        if (push) sb.push_back(e);

        if (r) begin
            mode = 0; m_fl = 0; m_npc = '0; m_tgt = '0; m_run = 0; m_ps = '0; m_pf = '0;
        end else begin
            m_ps = m_ps + {31'b0, e.stall[0]};
            m_pf = m_pf + {31'b0, m_fl};
            m_fl = 0;
            case (mode)
                0: begin
                    m_run = run_stall ? ((m_run < int'(TMO)) ? m_run + 1 : m_run) : 0;
                    if (exc != 0) begin
                        m_tgt = (exc == 32'hE) ? epc : 32'h20;
                        if (busy) mode = 1;
                        else begin mode = 2; m_fl = 1; m_npc = m_tgt; end
                    end
                end
                1: begin
                    m_run = 0;
                    if (!busy) begin mode = 2; m_fl = 1; m_npc = m_tgt; end
                end
                default: begin
                    m_run = 0;
                    mode  = 0;
                end
            endcase
        end
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, tag);
    endtask

    initial begin : stim
        logic [31:0] exc, epc;
        rst = 1; stallreq_if_i = 0; stallreq_id_i = 0; stallreq_ex_i = 0;
        stallreq_mem_i = 0; if_busy_i = 0; excepttype_i = '0; cp0_epc_i = '0;

        // Reset with every request active; first cycle's registers are still unknown.
        step(1, 1, 1, 1, 1, 1, 32'h1, 32'h123, 0, "rst1");
        step(1, 1, 1, 1, 1, 1, 32'h1, 32'h123, 1, "rst2");
        idle("post_rst");

        step(0, 0, 1, 1, 0, 0, 32'h0, 32'h0, 1, "id_ex");
        step(0, 0, 1, 1, 1, 0, 32'h0, 32'h0, 1, "id_ex_mem");
        step(0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 1, "if_only");
        idle("idle");

        step(0, 0, 0, 0, 0, 0, 32'h1, 32'h0, 1, "exc_n");
        idle("exc_n1");
        idle("exc_n2");

        step(0, 0, 0, 0, 0, 1, 32'hE, 32'h400, 1, "eret_n");
        step(0, 0, 0, 0, 0, 1, 32'hE, 32'h999, 1, "eret_n1");
        step(0, 0, 0, 0, 0, 1, 32'hE, 32'h999, 1, "eret_n2");
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0,   1, "eret_n3");
        idle("eret_n4");
        idle("eret_n5");

        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 1, "wd_a");
        idle("wd_gap");
        idle("wd_gap");
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 1, "wd_b");
        idle("wd_end");

        step(0, 0, 0, 0, 0, 1, 32'h3, 32'h0, 1, "drain_rst_n");
        step(0, 0, 0, 0, 0, 1, 32'h3, 32'h0, 1, "drain_rst_n1");
        step(1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 1, "drain_rst_r");
        for (int i = 0; i < 3; i++) idle("drain_rst_after");

        step(0, 0, 0, 0, 0, 0, 32'h1, 32'h0, 1, "flush_ign_n");
        step(0, 0, 0, 0, 0, 0, 32'h1, 32'h0, 1, "flush_ign_n1");
        idle("flush_ign_n2");
        idle("flush_ign_n3");

        step(0, 0, 0, 0, 0, 0, 32'h1, 32'h0,   1, "b2b_n");
        step(0, 0, 0, 0, 0, 0, 32'hE, 32'h800, 1, "b2b_n1");
        step(0, 0, 0, 0, 0, 0, 32'hE, 32'h800, 1, "b2b_n2");
        idle("b2b_n3");
        idle("b2b_n4");

        for (int i = 0; i < 3000; i++) begin
            exc = '0;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0:       exc = 32'h1;
                    1:       exc = 32'hE;
                    default: exc = $urandom | 32'h1;
                endcase
            end
            epc = $urandom;
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, exc, epc, 1, "rand");
        end
        idle("tail");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain scoreboard left=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
